// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the shift sequencer and its single-bit shifter.
//   state_e      : sequencer FSM states (IDLE, SHIFT, DONE)
//   DIR_*        : shiftDirection encodings understood by the shifter
//   TYPE_*       : shift_type encodings (1 = logical, 0 = arithmetic)
package shift_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    localparam logic [15:0] DIR_RIGHT = 16'hFFFF;
    localparam logic [15:0] DIR_LEFT  = 16'h0001;
    localparam logic [15:0] DIR_NONE  = 16'h0000;

    localparam logic TYPE_LOGICAL = 1'b1;
    localparam logic TYPE_ARITH   = 1'b0;

endpackage

// File: rtl/shift_sequencer_shifter.sv
// Single-position combinational shifter.
// Ports:
//   src            in  WIDTH  operand
//   shiftDirection in  16     DIR_LEFT = shift left by one, DIR_RIGHT = shift
//                             right by one, anything else passes src through
//   shiftType      in  1      logical/arithmetic select; both fill with zero
//   result         out WIDTH  shifted operand
module shifter
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] src,
    input  logic [15:0]      shiftDirection,
    input  logic             shiftType,
    output logic [WIDTH-1:0] result
);

    // Right shifts always fill with zero; sign extension is applied by the
    // sequencer when it is enabled, so the type bit does not affect the data.
    logic unused_shift_type;
    assign unused_shift_type = shiftType;

    always_comb begin
        result = src;
        if (shiftDirection == DIR_LEFT) begin
            result = {src[WIDTH-2:0], 1'b0};
        end else if (shiftDirection == DIR_RIGHT) begin
            result = {1'b0, src[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-bit shift controller: serialises a signed-distance shift onto the
// single-position shifter, one step per clock, and returns the result under a
// valid/ready handshake.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   start_valid/ready   request handshake (ready only in IDLE)
//   src                 operand (WIDTH)
//   amount              signed shift distance (AMT_W), >0 left, <0 right
//   shift_type          1 = logical, 0 = arithmetic
//   result              shifted value, stable while result_valid is high
//   result_valid/ready  result handshake
//   busy                high while a request is in flight (SHIFT or DONE)
// Build option: define SHIFT_SEQ_ARITH_EN to make arithmetic right shifts
// sign-extend; without it all right shifts zero-fill.
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int AMT_W = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] src,
    input  logic [AMT_W-1:0] amount,
    input  logic             shift_type,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             busy
);

    localparam logic [AMT_W:0] CNT_ONE = {{AMT_W{1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [AMT_W:0]   cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             type_q, type_d;
    logic             start_ready_q, start_ready_d;
    logic             result_valid_q, result_valid_d;
    logic             busy_q, busy_d;
`ifdef SHIFT_SEQ_ARITH_EN
    logic             sign_q, sign_d;
`endif

    logic [AMT_W:0]   amt_ext;
    logic [AMT_W:0]   amt_mag;
    logic [15:0]      shift_dir;
    logic [WIDTH-1:0] shift_out;

    // Magnitude is formed one bit wider so that the most negative amount
    // (-2**(AMT_W-1)) still yields a positive count.
    assign amt_ext = {amount[AMT_W-1], amount};
    assign amt_mag = amount[AMT_W-1] ? (~amt_ext + CNT_ONE) : amt_ext;

    assign shift_dir = (state_q == SHIFT) ? (dir_q ? DIR_RIGHT : DIR_LEFT) : DIR_NONE;

    shifter #(
        .WIDTH(WIDTH)
    ) u_shifter (
        .src            (acc_q),
        .shiftDirection (shift_dir),
        .shiftType      (type_q),
        .result         (shift_out)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        type_d  = type_q;
`ifdef SHIFT_SEQ_ARITH_EN
        sign_d  = sign_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start_valid && start_ready_q) begin
                    acc_d   = src;
                    dir_d   = amount[AMT_W-1];
                    cnt_d   = amt_mag;
                    type_d  = shift_type;
`ifdef SHIFT_SEQ_ARITH_EN
                    sign_d  = src[WIDTH-1];
`endif
                    state_d = (amt_mag == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                acc_d = shift_out;
`ifdef SHIFT_SEQ_ARITH_EN
                if (dir_q && (type_q == TYPE_ARITH)) begin
                    acc_d[WIDTH-1] = sign_q;
                end
`endif
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (result_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Handshake outputs are registered from the next state so they line
        // up with the state they describe.
        start_ready_d  = (state_d == IDLE);
        result_valid_d = (state_d == DONE);
        busy_d         = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            acc_q          <= '0;
            cnt_q          <= '0;
            dir_q          <= 1'b0;
            type_q         <= TYPE_LOGICAL;
            start_ready_q  <= 1'b1;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
`ifdef SHIFT_SEQ_ARITH_EN
            sign_q         <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            acc_q          <= acc_d;
            cnt_q          <= cnt_d;
            dir_q          <= dir_d;
            type_q         <= type_d;
            start_ready_q  <= start_ready_d;
            result_valid_q <= result_valid_d;
            busy_q         <= busy_d;
`ifdef SHIFT_SEQ_ARITH_EN
            sign_q         <= sign_d;
`endif
        end
    end

    assign start_ready  = start_ready_q;
    assign result_valid = result_valid_q;
    assign busy         = busy_q;
    assign result       = acc_q;

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;

    logic        clk;
    logic        reset_n;
    logic        start_valid;
    logic        start_ready;
    logic [15:0] src;
    logic [4:0]  amount;
    logic        shift_type;
    logic [15:0] result;
    logic        result_valid;
    logic        result_ready;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    shift_sequencer #(
        .WIDTH(16),
        .AMT_W(5)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .src          (src),
        .amount       (amount),
        .shift_type   (shift_type),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain arithmetic on the full signed distance.
    function automatic logic [15:0] ref_shift(input logic [15:0] s, input int a, input logic t);
        logic [31:0] w;
        int          x;
        w = {16'h0000, s};
        if (a >= 0) begin
            w = w << a;
            return w[15:0];
        end
`ifdef SHIFT_SEQ_ARITH_EN
        if (t == 1'b0) begin
            x = int'($signed(s));
            x = x >>> (-a);
            return 16'(x);
        end
`else
        x = 0;
        if (t) x = 0;
`endif
        w = w >> (-a);
        return w[15:0];
    endfunction

    function automatic int mag_of(input int a);
        return (a < 0) ? -a : a;
    endfunction

    // Issue one request and follow it through to the result handshake.
    // Called and returns at 1 time unit after a rising edge.
    task automatic run_req(input logic [15:0] s, input logic [4:0] a, input logic t, input int hold);
        logic signed [4:0] as;
        int                ai;
        int                n;
        int                edges;
        int                busy_cnt;
        int                wait_cnt;
        logic [15:0]       exp;
        as  = a;
        ai  = int'(as);
        n   = mag_of(ai);
        exp = ref_shift(s, ai, t);

        wait_cnt = 0;
        while (!start_ready && wait_cnt < 40) begin
            @(posedge clk); #1;
            wait_cnt++;
        end
        check("start_ready_idle", 32'(start_ready), 32'd1);

        start_valid  = 1'b1;
        src          = s;
        amount       = a;
        shift_type   = t;
        result_ready = (hold == 0);
        @(posedge clk); #1;
        start_valid = 1'b0;
        src         = 16'($urandom);
        amount      = 5'($urandom);
        shift_type  = 1'($urandom);

        edges    = 0;
        busy_cnt = 0;
        while (!result_valid && edges < 40) begin
            if (busy) busy_cnt++;
            check("ready_low_busy", 32'(start_ready), 32'd0);
            @(posedge clk); #1;
            edges++;
        end
        check("latency", 32'(edges), 32'(n));
        check("result", 32'(result), 32'(exp));
        if (busy) busy_cnt++;

        // Consumer stalls; a competing request must not be taken.
        for (int i = 0; i < hold; i++) begin
            start_valid = 1'b1;
            src         = 16'($urandom);
            amount      = 5'd3;
            @(posedge clk); #1;
            if (busy) busy_cnt++;
            check("hold_valid", 32'(result_valid), 32'd1);
            check("hold_result", 32'(result), 32'(exp));
            check("hold_start_ready", 32'(start_ready), 32'd0);
        end
        start_valid  = 1'b0;
        result_ready = 1'b1;
        @(posedge clk); #1;
        result_ready = 1'b0;
        check("post_valid", 32'(result_valid), 32'd0);
        check("post_start_ready", 32'(start_ready), 32'd1);
        check("post_busy", 32'(busy), 32'd0);
        check("post_result_hold", 32'(result), 32'(exp));
        check("busy_cycles", 32'(busy_cnt), 32'(n + 1 + hold));
    endtask

    initial begin
        logic [15:0] garbage;
        reset_n      = 1'b0;
        start_valid  = 1'b0;
        src          = '0;
        amount       = '0;
        shift_type   = 1'b1;
        result_ready = 1'b0;
        #12;
        check("rst_result", 32'(result), 32'd0);
        check("rst_valid", 32'(result_valid), 32'd0);
        check("rst_start_ready", 32'(start_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases.
        run_req(16'h00F0, 5'd4, 1'b1, 0);
        run_req(16'h8000, 5'b11101, 1'b0, 0);
        run_req(16'h1234, 5'd0, 1'b0, 0);
        run_req(16'hFFFF, 5'b10000, 1'b1, 0);
        run_req(16'hFFFF, 5'b10000, 1'b0, 0);
        run_req(16'h8001, 5'd15, 1'b0, 0);
        run_req(16'hA5C3, 5'd2, 1'b1, 10);

        // Reset during the third SHIFT cycle of a +8 request.
        start_valid = 1'b1;
        src         = 16'h0001;
        amount      = 5'd8;
        shift_type  = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        check("mid_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check("arst_result", 32'(result), 32'd0);
        check("arst_valid", 32'(result_valid), 32'd0);
        check("arst_start_ready", 32'(start_ready), 32'd1);
        check("arst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("arst_idle_result", 32'(result), 32'd0);
        run_req(16'h0001, 5'd8, 1'b1, 0);

        // Randomized requests.
        for (int i = 0; i < 40; i++) begin
            garbage = 16'($urandom);
            run_req(garbage, 5'($urandom_range(0, 31)), 1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        n_errors++;
        $display("FAIL timeout: got running expected finished");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
